pipelined_csa: RTL and testbench

PIPELINED_CSA -- requirements
Module: pipelined_csa

---
 rtl/pipelined_csa.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_csa.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csa.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Both candidate segment sums are formed on acceptance, and stage k resolves
// segment k from the carry out of stage k-1. The whole pipe stalls together.
module pipelined_csa #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG;
  // Internal stages 0..NSEG-2 carry the unresolved pairs of segments 1..NSEG-1
  localparam int unsigned NHI  = (NSEG > 1) ? NSEG - 1 : 1;

  typedef logic [NSEG-1:0][SEG-1:0] seg_t;
  typedef logic [NHI-1:0][SEG-1:0]  hi_t;

  // Stage registers; unresolved segments of sum_q hold their carry-in-0 sum
  logic [NHI-1:0] vld_q, rc_q, sa_q, sb_q;
  seg_t           sum_q [NHI];
  hi_t            alt_q [NHI];
  logic [NHI-1:0] c0_q  [NHI];
  logic [NHI-1:0] c1_q  [NHI];

  logic [NHI-1:0] vld_d, rc_d, sa_d, sb_d;
  seg_t           sum_d [NHI];
  hi_t            alt_d [NHI];
  logic [NHI-1:0] c0_d  [NHI];
  logic [NHI-1:0] c1_d  [NHI];

  logic           ov_d, oc_d, oo_d;
  seg_t           os_d;

  logic           advance;
  logic [WIDTH-1:0] bb;
  logic           ec;
  seg_t           a_s, b_s, p0s, p1s;
  logic [NSEG-1:0] p0c, p1c;
  hi_t            hi_alt;
  logic [NHI-1:0] hi_c0, hi_c1;
  seg_t           nsum;
  logic           nrc, nsa, nsb, nvld;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign bb       = sub ? ~b : b;
  assign ec       = sub | cin;
  assign a_s      = a;
  assign b_s      = bb;

  // Candidate sum/carry of every segment for carry-in 0 and carry-in 1
  always_comb begin
    p0s = '0;
    p1s = '0;
    p0c = '0;
    p1c = '0;
    for (int unsigned j = 0; j < NSEG; j++) begin
      {p0c[j], p0s[j]} = {1'b0, a_s[j]} + {1'b0, b_s[j]};
      {p1c[j], p1s[j]} = {1'b0, a_s[j]} + {1'b0, b_s[j]} + (SEG+1)'(1);
    end
  end

  // Per-stage carry select: one segment resolved per stage, last feeds outputs
  always_comb begin
    vld_d = '0;
    rc_d  = '0;
    sa_d  = '0;
    sb_d  = '0;
    for (int unsigned i = 0; i < NHI; i++) begin
      sum_d[i] = '0;
      alt_d[i] = '0;
      c0_d[i]  = '0;
      c1_d[i]  = '0;
    end
    ov_d   = 1'b0;
    os_d   = '0;
    oc_d   = 1'b0;
    oo_d   = 1'b0;
    hi_alt = '0;
    hi_c0  = '0;
    hi_c1  = '0;
    for (int unsigned j = 1; j < NSEG; j++) begin
      hi_alt[j-1] = p1s[j];
      hi_c0[j-1]  = p0c[j];
      hi_c1[j-1]  = p1c[j];
    end

    // stage 0 resolves segment 0 directly from the effective carry-in
    nsum    = p0s;
    nsum[0] = ec ? p1s[0] : p0s[0];
    nrc     = ec ? p1c[0] : p0c[0];
    nsa     = a[WIDTH-1];
    nsb     = bb[WIDTH-1];
    nvld    = in_valid;
    if (NSEG == 1) begin
      ov_d = nvld;
      os_d = nsum;
      oc_d = nrc;
      oo_d = (nsa == nsb) && (nsum[NSEG-1][SEG-1] != nsa);
    end else begin
      vld_d[0] = nvld;
      sum_d[0] = nsum;
      rc_d[0]  = nrc;
      sa_d[0]  = nsa;
      sb_d[0]  = nsb;
      alt_d[0] = hi_alt;
      c0_d[0]  = hi_c0;
      c1_d[0]  = hi_c1;
    end

    for (int unsigned k = 1; k < NSEG; k++) begin
      nsum    = sum_q[k-1];
      nsum[k] = rc_q[k-1] ? alt_q[k-1][k-1] : sum_q[k-1][k];
      nrc     = rc_q[k-1] ? c1_q[k-1][k-1] : c0_q[k-1][k-1];
      if (k == NSEG - 1) begin
        ov_d = vld_q[k-1];
        os_d = nsum;
        oc_d = nrc;
        oo_d = (sa_q[k-1] == sb_q[k-1]) && (nsum[NSEG-1][SEG-1] != sa_q[k-1]);
      end else begin
        vld_d[k] = vld_q[k-1];
        sum_d[k] = nsum;
        rc_d[k]  = nrc;
        sa_d[k]  = sa_q[k-1];
        sb_d[k]  = sb_q[k-1];
        alt_d[k] = alt_q[k-1];
        c0_d[k]  = c0_q[k-1];
        c1_d[k]  = c1_q[k-1];
      end
    end
  end

  // Pipeline registers: shift together on advance, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      rc_q      <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      for (int unsigned i = 0; i < NHI; i++) begin
        sum_q[i] <= '0;
        alt_q[i] <= '0;
        c0_q[i]  <= '0;
        c1_q[i]  <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      vld_q     <= vld_d;
      rc_q      <= rc_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      for (int unsigned i = 0; i < NHI; i++) begin
        sum_q[i] <= sum_d[i];
        alt_q[i] <= alt_d[i];
        c0_q[i]  <= c0_d[i];
        c1_q[i]  <= c1_d[i];
      end
      out_valid <= ov_d;
      sum       <= os_d;
      carry     <= oc_d;
      ovf       <= oo_d;
    end
  end

endmodule

// File: tb/tb_pipelined_csa.sv
// Self-checking bench for pipelined_csa at WIDTH=16, SEG=4.
module tb_pipelined_csa;

  localparam int unsigned W    = 16;
  localparam int unsigned S    = 4;
  localparam int unsigned NSEG = W / S;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } res_t;

  res_t exp_q[$];

  pipelined_csa #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on unsigned and signed interpretations
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fcin, input logic fsub);
    longint m, ua, ub, sa, sb, u, s;
    res_t r;
    m  = longint'(1) << W;
    ua = longint'(fa);
    ub = longint'(fb);
    sa = fa[W-1] ? ua - m : ua;
    sb = fb[W-1] ? ub - m : ub;
    if (!fsub) begin
      u = ua + ub + longint'(fcin);
      s = sa + sb + longint'(fcin);
      r.carry = (u >= m);
    end else begin
      u = ua - ub;
      s = sa - sb;
      r.carry = (ua >= ub);
    end
    r.sum = W'(u);
    r.ovf = (s >= m / 2) || (s < -(m / 2));
    return r;
  endfunction

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", sum); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", carry); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h000F, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    logic [W-1:0] tb [6] = '{16'h00F0, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
    logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [6] = '{16'h00FF, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h2469};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      int  lat;
      logic got;
      @(negedge clk);
      a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
        if (out_valid) got = 1'b1;
      end
      n_checks++; if (!got || lat != NSEG) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, NSEG); end
      n_checks++; if (sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum, es[i]); end
      n_checks++; if (carry !== ec[i]) begin n_fail++; $display("FAIL dir%0d_carry: got %b expected %b", i, carry, ec[i]); end
      n_checks++; if (ovf !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b expected %b", i, ovf, eo[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   rcv  = 0;
    logic held = 1'b0;
    logic stall;
    res_t hv, e;
    exp_q.delete();
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      @(negedge clk);
      stall = (c >= 5 && c <= 7);
      out_ready = !stall;
      if (sent < 8) begin
        in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready c%0d: got %b expected 0", c, in_ready); end
      end
      if (held) begin
        n_checks++;
        if (out_valid !== 1'b1 || {sum, carry, ovf} !== hv) begin
          n_fail++; $display("FAIL b2b_hold c%0d: got %b/%h expected 1/%h", c, out_valid, {sum, carry, ovf}, hv);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_beat: got sum %h expected no beat", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, carry, ovf} !== e) begin n_fail++; $display("FAIL b2b_result%0d: got %h expected %h", rcv, {sum, carry, ovf}, e); end
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      held = out_valid && !out_ready;
      hv   = {sum, carry, ovf};
    end
    in_valid = 1'b0;
    n_checks++; if (rcv != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", rcv); end
  endtask

  task automatic test_reset_midstream();
    int   lat;
    logic got;
    logic seen;
    res_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
    end
    got = 1'b0; lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL mid_prefill: got out_valid 0 expected 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL mid_ghost_beat: got a beat expected none"); end
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); cin = 1'b1; sub = 1'b1;
    e = model(a, b, cin, sub);
    in_valid = 1'b1;
    @(posedge clk);
    got = 1'b0; lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1'b1;
    end
    n_checks++; if (!got || lat != NSEG) begin n_fail++; $display("FAIL mid_post_latency: got %0d expected %0d", lat, NSEG); end
    n_checks++; if ({sum, carry, ovf} !== e) begin n_fail++; $display("FAIL mid_post_result: got %h expected %h", {sum, carry, ovf}, e); end
  endtask

  task automatic test_soak();
    logic held = 1'b0;
    res_t hv, e;
    int   nout = 0;
    exp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (c % 5 == 0) b = a;
      if (c % 7 == 0) a = {1'b0, {(W-1){1'b1}}};
      #1;
      n_checks++; if (in_ready !== (!out_valid || out_ready)) begin n_fail++; $display("FAIL soak_in_ready c%0d: got %b expected %b", c, in_ready, (!out_valid || out_ready)); end
      if (held) begin
        n_checks++;
        if (out_valid !== 1'b1 || {sum, carry, ovf} !== hv) begin
          n_fail++; $display("FAIL soak_hold c%0d: got %b/%h expected 1/%h", c, out_valid, {sum, carry, ovf}, hv);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL soak_extra_beat c%0d: got sum %h expected no beat", c, sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, carry, ovf} !== e) begin n_fail++; $display("FAIL soak_result%0d: got %h expected %h", nout, {sum, carry, ovf}, e); end
        end
        nout++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      held = out_valid && !out_ready;
      hv   = {sum, carry, ovf};
    end
    in_valid = 1'b0;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        n_checks++;
        e = exp_q.pop_front();
        if ({sum, carry, ovf} !== e) begin n_fail++; $display("FAIL soak_drain%0d: got %h expected %h", c, {sum, carry, ovf}, e); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL soak_lost_beats: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
